pixel_write_queue: RTL and testbench
====================================

Name: pixel_write_queue

Overview:
- Sits directly downstream of the board painter.
- Converts the painter's level-style write strobe into single-cycle pixel writes to the VGA framebuffer adapter.
- Buffers writes in a small FIFO so painter timing is decoupled from the framebuffer port.
- Provides a full-screen clear engine that fills the framebuffer with a background colour on request.

Parameters:
- SCR_WIDTH, 160, screen width in pixels
- SCR_HEIGHT, 120, screen height in pixels
- X_BITS, 8, x coordinate width
- Y_BITS, 7, y coordinate width
- COLOR_SIZE, 3, colour width
- FIFO_DEPTH, 8, queued write entries (power of two)
- BG_COLOR, 3'b000, colour used by the clear engine

Ports:
- Clck  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous active-low reset
- paint_x_co  in  X_BITS  painter x coordinate
- paint_y_co  in  Y_BITS  painter y coordinate
- color  in  COLOR_SIZE  painter colour
- print_enable  in  1  painter write strobe; level may stay high for several cycles
- clear_req  in  1  request a full-screen clear
- vga_x  out  X_BITS  framebuffer write x
- vga_y  out  Y_BITS  framebuffer write y
- vga_colour  out  COLOR_SIZE  framebuffer write colour
- vga_plot  out  1  one-cycle write strobe
- busy  out  1  high while clearing or FIFO non-empty
- overflow  out  1  sticky; a request was dropped

Behaviour:
- Reset (Reset==0 at posedge):
  - All outputs 0; FIFO emptied; state IDLE; clear counters 0.
  - Previous-strobe register and clear-pending flag cleared.
  - Reset mid-clear or mid-drain abandons the operation immediately.
- Request detection:
  - A write request is print_enable==1 sampled with the registered previous value==0 (rising edge).
  - Exactly one request per high pulse, regardless of pulse length.
  - paint_x_co, paint_y_co and color are captured in the same cycle as the edge.
- Push rule:
  - Accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the request is dropped and overflow is set; overflow clears only on reset.
- clear_req:
  - A rising edge sets clear-pending.
  - An edge while already CLEAR or already pending is ignored.
- State machine, one pixel output per cycle maximum:
  - IDLE:
    - If clear-pending: go to CLEAR, set cx=0, cy=0, clear clear-pending.
    - Else if FIFO non-empty: pop the head this cycle and register it onto vga_x/vga_y/vga_colour with vga_plot=1 next cycle. Stay in IDLE, so back-to-back pops stream at 1 pixel/cycle.
    - Else vga_plot=0.
  - CLEAR:
    - Each cycle emits (cx, cy, BG_COLOR) with vga_plot=1.
    - cx increments; at cx==SCR_WIDTH-1, cx wraps to 0 and cy increments.
    - After (SCR_WIDTH-1, SCR_HEIGHT-1) is emitted, return to IDLE.
    - Total SCR_WIDTH*SCR_HEIGHT cycles (19200 at defaults).
    - FIFO pops are suspended; pushes continue and queued writes drain after the clear.
    - Clear has priority over queued writes when both are pending in IDLE.
- Latency: a request edge sampled at posedge N with the FIFO empty and IDLE gives vga_plot=1 with its data after posedge N+1. Push and pop are never combinationally bypassed.
- vga_x/vga_y/vga_colour hold their last value when vga_plot=0.
- busy = (state==CLEAR) | clear-pending | (count!=0) | vga_plot.
- Count width is log2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset held low 3 cycles with print_enable=1 -> all outputs 0, no plot; release with print_enable still high -> no request (previous-strobe register resets to 0 but the edge needs a low first; no plot generated).
- Single pulse, print_enable high 4 cycles with (x=10, y=20, colour=3'b110) -> exactly one vga_plot cycle, 2 posedges after the edge, vga_x=10, vga_y=20, vga_colour=6; busy returns to 0.
- 10 edges 2 cycles apart -> 10 plots in order with matching data, overflow=0.
- clear_req pulse, then 12 write edges during the clear -> 19200 plots of BG_COLOR, last one at (159,119); then the first 8 queued writes plot in order; overflow=1; exactly 8 of the 12 writes are output.
- Reset asserted at clear pixel (50,3) -> vga_plot=0 next cycle, busy=0; a new clear restarts at (0,0).
- Second clear_req edge mid-clear -> ignored; clear completes after exactly 19200 plots total.

Source files
------------

// File: rtl/pixel_write_queue.sv
// Painter-to-framebuffer write queue: edge-detects the painter strobe, buffers
// writes in a small FIFO and runs a full-screen background clear on request.
module pixel_write_queue #(
    parameter int unsigned           SCR_WIDTH  = 160,
    parameter int unsigned           SCR_HEIGHT = 120,
    parameter int unsigned           X_BITS     = 8,
    parameter int unsigned           Y_BITS     = 7,
    parameter int unsigned           COLOR_SIZE = 3,
    parameter int unsigned           FIFO_DEPTH = 8,
    parameter logic [COLOR_SIZE-1:0] BG_COLOR   = 3'b000
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic [X_BITS-1:0]     paint_x_co,
    input  logic [Y_BITS-1:0]     paint_y_co,
    input  logic [COLOR_SIZE-1:0] color,
    input  logic                  print_enable,
    input  logic                  clear_req,
    output logic [X_BITS-1:0]     vga_x,
    output logic [Y_BITS-1:0]     vga_y,
    output logic [COLOR_SIZE-1:0] vga_colour,
    output logic                  vga_plot,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS   = PTR_BITS + 1;
    localparam int unsigned ENTRY_BITS = X_BITS + Y_BITS + COLOR_SIZE;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [CNT_BITS-1:0]   CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0]   CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0]   CNT_FULL = CNT_BITS'(FIFO_DEPTH);
    localparam logic [PTR_BITS-1:0]   PTR_ZERO = {PTR_BITS{1'b0}};
    localparam logic [PTR_BITS-1:0]   PTR_ONE  = {{(PTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [X_BITS-1:0]     X_ZERO   = {X_BITS{1'b0}};
    localparam logic [X_BITS-1:0]     X_ONE    = {{(X_BITS-1){1'b0}}, 1'b1};
    localparam logic [X_BITS-1:0]     X_LAST   = X_BITS'(SCR_WIDTH - 1);
    localparam logic [Y_BITS-1:0]     Y_ZERO   = {Y_BITS{1'b0}};
    localparam logic [Y_BITS-1:0]     Y_ONE    = {{(Y_BITS-1){1'b0}}, 1'b1};
    localparam logic [Y_BITS-1:0]     Y_LAST   = Y_BITS'(SCR_HEIGHT - 1);
    localparam logic [COLOR_SIZE-1:0] C_ZERO   = {COLOR_SIZE{1'b0}};

    logic [0:0]            state_r;
    logic                  pending_r;
    logic                  prev_pe_r;
    logic                  armed_r;
    logic                  prev_clr_r;
    logic [X_BITS-1:0]     cx_r;
    logic [Y_BITS-1:0]     cy_r;
    logic [PTR_BITS-1:0]   wr_ptr_r;
    logic [PTR_BITS-1:0]   rd_ptr_r;
    logic [CNT_BITS-1:0]   count_r;
    logic [ENTRY_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [X_BITS-1:0]     x_r;
    logic [Y_BITS-1:0]     y_r;
    logic [COLOR_SIZE-1:0] col_r;
    logic                  plot_r;
    logic                  busy_r;
    logic                  overflow_r;

    logic                  req_s;
    logic                  clr_edge_s;
    logic                  pop_s;
    logic                  push_s;
    logic [ENTRY_BITS-1:0] head_s;
    logic [0:0]            state_nx_s;
    logic                  pending_nx_s;
    logic [X_BITS-1:0]     cx_nx_s;
    logic [Y_BITS-1:0]     cy_nx_s;
    logic [CNT_BITS-1:0]   count_nx_s;
    logic [X_BITS-1:0]     x_nx_s;
    logic [Y_BITS-1:0]     y_nx_s;
    logic [COLOR_SIZE-1:0] col_nx_s;
    logic                  plot_nx_s;
    logic                  busy_nx_s;

    // Request detection, FIFO push/pop decisions and occupancy update
    always_comb begin
        // armed_r demands a low strobe after reset, so a level held across reset is not a request
        req_s      = print_enable & ~prev_pe_r & armed_r;
        clr_edge_s = clear_req & ~prev_clr_r;
        pop_s      = (state_r == IDLE) & ~pending_r & (count_r != CNT_ZERO);
        push_s     = req_s & ((count_r != CNT_FULL) | pop_s);
        head_s     = mem_r[rd_ptr_r];
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase
    end

    // Pixel sequencer: clear sweep or FIFO drain, one pixel per cycle at most
    always_comb begin
        state_nx_s   = state_r;
        pending_nx_s = pending_r;
        cx_nx_s      = cx_r;
        cy_nx_s      = cy_r;
        x_nx_s       = x_r;
        y_nx_s       = y_r;
        col_nx_s     = col_r;
        plot_nx_s    = 1'b0;
        if (clr_edge_s && (state_r != CLEAR) && !pending_r) begin
            pending_nx_s = 1'b1;
        end else begin
            pending_nx_s = pending_r;
        end
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    state_nx_s   = CLEAR;
                    pending_nx_s = 1'b0;
                    cx_nx_s      = X_ZERO;
                    cy_nx_s      = Y_ZERO;
                end else if (pop_s) begin
                    plot_nx_s = 1'b1;
                    {x_nx_s, y_nx_s, col_nx_s} = head_s;
                end else begin
                    plot_nx_s = 1'b0;
                end
            end
            CLEAR: begin
                plot_nx_s = 1'b1;
                x_nx_s    = cx_r;
                y_nx_s    = cy_r;
                col_nx_s  = BG_COLOR;
                if (cx_r == X_LAST) begin
                    cx_nx_s = X_ZERO;
                    if (cy_r == Y_LAST) begin
                        cy_nx_s    = Y_ZERO;
                        state_nx_s = IDLE;
                    end else begin
                        cy_nx_s = cy_r + Y_ONE;
                    end
                end else begin
                    cx_nx_s = cx_r + X_ONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                plot_nx_s  = 1'b0;
            end
        endcase
        busy_nx_s = (state_nx_s == CLEAR) | pending_nx_s | (count_nx_s != CNT_ZERO) | plot_nx_s;
    end

    // Control, counters, FIFO pointers and registered outputs
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state_r    <= IDLE;
            pending_r  <= 1'b0;
            prev_pe_r  <= 1'b0;
            armed_r    <= 1'b0;
            prev_clr_r <= 1'b0;
            cx_r       <= X_ZERO;
            cy_r       <= Y_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            x_r        <= X_ZERO;
            y_r        <= Y_ZERO;
            col_r      <= C_ZERO;
            plot_r     <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            pending_r  <= pending_nx_s;
            prev_pe_r  <= print_enable;
            armed_r    <= armed_r | ~print_enable;
            prev_clr_r <= clear_req;
            cx_r       <= cx_nx_s;
            cy_r       <= cy_nx_s;
            wr_ptr_r   <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r   <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            count_r    <= count_nx_s;
            x_r        <= x_nx_s;
            y_r        <= y_nx_s;
            col_r      <= col_nx_s;
            plot_r     <= plot_nx_s;
            busy_r     <= busy_nx_s;
            overflow_r <= overflow_r | (req_s & ~push_s);
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge Clck) begin
        if (Reset && push_s) begin
            mem_r[wr_ptr_r] <= {paint_x_co, paint_y_co, color};
        end
    end

    assign vga_x      = x_r;
    assign vga_y      = y_r;
    assign vga_colour = col_r;
    assign vga_plot   = plot_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: a vector table for reset and single
// writes, then hand-written sequences for streaming, clear and overflow.
module tb_pixel_write_queue;

    logic       Clck;
    logic       Reset;
    logic [7:0] paint_x_co;
    logic [6:0] paint_y_co;
    logic [2:0] color;
    logic       print_enable;
    logic       clear_req;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       overflow;

    pixel_write_queue dut (
        .Clck(Clck), .Reset(Reset),
        .paint_x_co(paint_x_co), .paint_y_co(paint_y_co), .color(color),
        .print_enable(print_enable), .clear_req(clear_req),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .overflow(overflow)
    );

    initial Clck = 1'b0;
    always #5 Clck = ~Clck;

    typedef struct {
        logic       rst_n;
        logic       pe;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       clr;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
        logic       e_busy;
        logic       e_ovf;
    } vec_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    vec_t vecs [11];
    pix_t cap_q [$];
    pix_t wr_q [$];
    int   errors = 0;
    int   checks = 0;

    // Record every plotted pixel mid-cycle, away from the active edge
    always @(negedge Clck) begin
        if (vga_plot === 1'b1) cap_q.push_back('{vga_x, vga_y, vga_colour});
    end

    task automatic tick();
        @(posedge Clck);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int bad;
        int found;
        Reset = 1'b0; print_enable = 1'b0; clear_req = 1'b0;
        paint_x_co = 8'd0; paint_y_co = 7'd0; color = 3'd0;

        // rst_n pe x y c clr | plot x y c busy ovf
        vecs[0]  = '{1'b0, 1'b1, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'd99, 7'd99, 3'd1, 1'b0, 1'b1, 8'd10, 7'd20, 3'd6, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'd99, 7'd99, 3'd1, 1'b0, 1'b0, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'd99, 7'd99, 3'd1, 1'b0, 1'b0, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'd99, 7'd99, 3'd1, 1'b0, 1'b0, 8'd10, 7'd20, 3'd6, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            Reset = vecs[i].rst_n; print_enable = vecs[i].pe; clear_req = vecs[i].clr;
            paint_x_co = vecs[i].x; paint_y_co = vecs[i].y; color = vecs[i].c;
            tick();
            chk($sformatf("v%0d_plot", i), {31'd0, vga_plot}, {31'd0, vecs[i].e_plot});
            chk($sformatf("v%0d_x", i), {24'd0, vga_x}, {24'd0, vecs[i].e_x});
            chk($sformatf("v%0d_y", i), {25'd0, vga_y}, {25'd0, vecs[i].e_y});
            chk($sformatf("v%0d_c", i), {29'd0, vga_colour}, {29'd0, vecs[i].e_c});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
        end

        // Ten writes two cycles apart stream out in order
        cap_q.delete();
        for (int i = 0; i < 10; i++) begin
            print_enable = 1'b1;
            paint_x_co = 8'(i * 7 + 1); paint_y_co = 7'(i + 3); color = 3'(i);
            tick();
            print_enable = 1'b0;
            tick();
            chk($sformatf("a%0d_lat_plot", i), {31'd0, vga_plot}, 32'd1);
            chk($sformatf("a%0d_lat_x", i), {24'd0, vga_x}, 32'(i * 7 + 1));
        end
        repeat (3) tick();
        chk("a_count", cap_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < cap_q.size(); i++) begin
            chk($sformatf("a%0d_data", i), {14'd0, cap_q[i]}, {14'd0, 8'(i * 7 + 1), 7'(i + 3), 3'(i)});
        end
        chk("a_ovf", {31'd0, overflow}, 32'd0);
        chk("a_busy", {31'd0, busy}, 32'd0);

        // Clear with twelve writes arriving during the sweep
        cap_q.delete();
        wr_q.delete();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            print_enable = 1'b1;
            paint_x_co = 8'(200 + i); paint_y_co = 7'(i); color = 3'((i % 7) + 1);
            wr_q.push_back('{8'(200 + i), 7'(i), 3'((i % 7) + 1)});
            tick();
            print_enable = 1'b0;
            tick();
        end
        wait_idle("b_timeout", 25000);
        repeat (2) tick();
        chk("b_count", cap_q.size(), 32'd19208);
        bad = 0;
        for (int k = 0; k < 19200 && k < cap_q.size(); k++) begin
            if (cap_q[k] !== pix_t'({8'(k % 160), 7'(k / 160), 3'd0})) bad++;
        end
        chk("b_clear_bad", bad, 32'd0);
        if (cap_q.size() >= 19200) begin
            chk("b_last_x", {24'd0, cap_q[19199].x}, 32'd159);
            chk("b_last_y", {25'd0, cap_q[19199].y}, 32'd119);
        end else begin
            chk("b_last_present", cap_q.size(), 32'd19200);
        end
        for (int i = 0; i < 8; i++) begin
            if (19200 + i < cap_q.size())
                chk($sformatf("b_q%0d", i), {14'd0, cap_q[19200 + i]}, {14'd0, wr_q[i]});
            else
                chk($sformatf("b_q%0d_present", i), cap_q.size(), 32'(19201 + i));
        end
        chk("b_ovf", {31'd0, overflow}, 32'd1);

        // Reset abandons a clear at pixel (50,3)
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        found = 0;
        for (int n = 0; n < 1000 && found == 0; n++) begin
            tick();
            if (vga_plot === 1'b1 && vga_x == 8'd50 && vga_y == 7'd3) found = 1;
        end
        chk("c_found", found, 32'd1);
        Reset = 1'b0;
        tick();
        chk("c_plot", {31'd0, vga_plot}, 32'd0);
        chk("c_busy", {31'd0, busy}, 32'd0);
        chk("c_x", {24'd0, vga_x}, 32'd0);
        chk("c_ovf", {31'd0, overflow}, 32'd0);
        Reset = 1'b1;
        tick();

        // Restarted clear begins at (0,0); a second request mid-sweep is ignored
        cap_q.delete();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle("d_timeout", 25000);
        repeat (20) tick();
        chk("d_count", cap_q.size(), 32'd19200);
        if (cap_q.size() > 0) begin
            chk("d_first", {14'd0, cap_q[0]}, 32'd0);
            chk("d_last", {14'd0, cap_q[cap_q.size() - 1]}, {14'd0, 8'd159, 7'd119, 3'd0});
        end else begin
            chk("d_first_present", cap_q.size(), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
